// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - sel encodings, FSM state type, lane masks and lane helpers
// Shared by mips_data_mem_port and mips_load_extend; byte-enable helpers serve MIPS_MEM_BYTE_ENABLE_EN builds.
package mips_mem_pkg;

  localparam logic [2:0] SEL_LB  = 3'b000;
  localparam logic [2:0] SEL_LBU = 3'b001;
  localparam logic [2:0] SEL_LH  = 3'b010;
  localparam logic [2:0] SEL_LHU = 3'b011;
  localparam logic [2:0] SEL_LW  = 3'b100;
  localparam logic [2:0] SEL_SB  = 3'b101;
  localparam logic [2:0] SEL_SH  = 3'b110;
  localparam logic [2:0] SEL_SW  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_t;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_half(input logic [2:0] sel);
    return (sel == SEL_LH) || (sel == SEL_LHU) || (sel == SEL_SH);
  endfunction

  function automatic logic is_word(input logic [2:0] sel);
    return (sel == SEL_LW) || (sel == SEL_SW);
  endfunction

  function automatic logic is_aligned(input logic [2:0] sel, input logic [1:0] lane);
    if (is_half(sel)) return !lane[0];
    if (is_word(sel)) return lane == 2'b00;
    return 1'b1;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] sel, input logic [1:0] lane);
    case (sel)
      SEL_SB:  return BE_BYTE << lane;
      SEL_SH:  return lane[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] wdata_lanes(input logic [2:0] sel, input logic [31:0] wdata);
    case (sel)
      SEL_SB:  return {4{wdata[7:0]}};
      SEL_SH:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Read-modify-write merge: only the addressed byte/halfword of the old word is replaced.
  function automatic logic [31:0] rmw_merge(input logic [31:0] word, input logic [15:0] data,
                                            input logic [2:0] sel, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    if (sel == SEL_SB) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = data;
    end else begin
      r[15:0] = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_load_extend.sv
// rtl/mips_load_extend.sv - little-endian lane select with zero/sign extension for loads
module mips_load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  sel,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (addr)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = addr[1] ? word[31:16] : word[15:0];

    case (sel)
      SEL_LB:  result = {{24{byte_lane[7]}}, byte_lane};
      SEL_LBU: result = {24'b0, byte_lane};
      SEL_LH:  result = {{16{half_lane[15]}}, half_lane};
      SEL_LHU: result = {16'b0, half_lane};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mips_data_mem_port.sv
// rtl/mips_data_mem_port.sv - MIPS data memory port: request FSM, RMW sub-word stores, load extension
// Define MIPS_MEM_BYTE_ENABLE_EN to add m_be and write sb/sh directly with byte enables.
module mips_data_mem_port
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        m_req,
  output logic        m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
`ifdef MIPS_MEM_BYTE_ENABLE_EN
  output logic [3:0]  m_be,
`endif
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  state_t      state, next_state;
  logic [1:0]  lane_q;
  logic [2:0]  sel_q;
  logic        is_store_q;
  logic [31:0] load_word;
`ifndef MIPS_MEM_BYTE_ENABLE_EN
  logic [15:0] wdata_q;
`endif

  logic is_load_req, is_store_req, legal, direct_wr;

  always_comb begin
    is_load_req  = mem_read & ~mem_write;
    is_store_req = mem_write & ~mem_read;
    legal        = ((is_load_req && sel <= SEL_LW) || (is_store_req && sel >= SEL_SB))
                   && is_aligned(sel, addr[1:0]);
`ifdef MIPS_MEM_BYTE_ENABLE_EN
    direct_wr    = is_store_req;
`else
    direct_wr    = is_store_req && (sel == SEL_SW);
`endif
  end

  mips_load_extend u_load_extend (
    .word   (m_rdata),
    .addr   (lane_q),
    .sel    (sel_q),
    .result (load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    m_req      = 1'b0;
    m_we       = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!legal)         next_state = ST_RESP;
          else if (direct_wr) next_state = ST_WR;
          else                next_state = ST_RD;
        end
      end
      ST_RD: begin
        m_req = 1'b1;
        if (m_ack) next_state = is_store_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        m_req = 1'b1;
        m_we  = 1'b1;
        if (m_ack) next_state = ST_RESP;
      end
      default: begin
        rsp_valid  = 1'b1;
        next_state = ST_IDLE;
      end
    endcase
  end

  // err is only written on the way into RESP so it holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q     <= 2'b0;
      sel_q      <= SEL_LB;
      is_store_q <= 1'b0;
      m_addr     <= 30'b0;
      m_wdata    <= 32'b0;
      rdata      <= 32'b0;
      err        <= 1'b0;
`ifdef MIPS_MEM_BYTE_ENABLE_EN
      m_be       <= 4'b0;
`else
      wdata_q    <= 16'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lane_q     <= addr[1:0];
            sel_q      <= sel;
            is_store_q <= is_store_req;
            m_addr     <= addr[31:2];
`ifdef MIPS_MEM_BYTE_ENABLE_EN
            m_wdata    <= wdata_lanes(sel, wdata);
            m_be       <= is_store_req ? lane_mask(sel, addr[1:0]) : BE_WORD;
`else
            m_wdata    <= wdata;
            wdata_q    <= wdata[15:0];
`endif
            if (!legal) err <= 1'b1;
          end
        end
        ST_RD: begin
          if (m_ack) begin
            if (is_store_q) begin
`ifndef MIPS_MEM_BYTE_ENABLE_EN
              m_wdata <= rmw_merge(m_rdata, wdata_q, sel_q, lane_q);
`endif
            end else begin
              rdata <= load_word;
              err   <= 1'b0;
            end
          end
        end
        ST_WR: begin
          if (m_ack) err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_data_mem_port.md
MIPS_DATA_MEM_PORT -- requirements
Module: mips_data_mem_port

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `req_valid` input 1 and `req_ready` output 1: core request handshake.
REQ-004 SHALL have `mem_read` input 1, `mem_write` input 1 and `sel` input 3 (size/sign select); all three come from the control decoder.
REQ-005 SHALL have `addr` input 32 (byte address) and `wdata` input 32 (store data, low bits significant).
REQ-006 SHALL have `rsp_valid` output 1, `rdata` output 32 (extended load data) and `err` output 1 (request rejected).
REQ-007 SHALL have memory-side ports: `m_req` out 1, `m_we` out 1, `m_addr` out 30 (word address = addr[31:2]), `m_wdata` out 32, `m_ack` in 1, `m_rdata` in 32.

Function
REQ-008 SHALL decode `sel` as follows. Loads: 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw. Stores: 101 sb, 110 sh, 111 sw.
REQ-009 SHALL use little-endian byte lanes: byte lane = addr[1:0]; halfword lane = addr[1].
REQ-010 SHALL implement FSM states IDLE, RD, WR, RESP; `req_ready` = 1 only in IDLE.
REQ-011 SHALL accept a request only on a cycle with req_valid & req_ready, registering addr, wdata, sel and direction.
REQ-012 SHALL route an accepted, legal request as follows: a load goes to RD; sw goes to WR; sb/sh go to RD (read-modify-write).
REQ-013 SHALL treat a request as illegal in these cases, sending it to RESP with err=1 and never asserting m_req:
- both or neither of mem_read/mem_write set;
- a load with sel in 101..111, or a store with sel in 000..100;
- a misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠00.
REQ-014 SHALL drive m_req=1 throughout RD and WR, with m_we=1 only in WR, and hold m_addr/m_wdata stable while m_req=1.
REQ-015 SHALL wait indefinitely in RD/WR until m_ack=1; m_ack outside RD/WR SHALL be ignored.
REQ-016 SHALL act on m_ack in RD as follows: a load captures the selected lane, zero- or sign-extended per sel, into rdata and goes to RESP; sb/sh merge wdata[7:0]/[15:0] into the m_rdata lane, leave the other bytes unchanged, and go to WR.
REQ-017 SHALL go from WR to RESP on m_ack; rdata is unchanged by stores.
REQ-018 SHALL assert rsp_valid for exactly one cycle in RESP, with err valid that cycle, then return to IDLE.
REQ-019 SHALL hold rdata and err between responses.
REQ-020 SHALL have these latencies with zero-wait memory (acceptance at cycle T): load or sw responds at T+2; sb/sh RMW at T+3; illegal request at T+1. Each memory wait cycle adds one.

Reset
REQ-021 SHALL, on reset, set state=IDLE, req_ready=1, m_req=0, m_we=0, rsp_valid=0, rdata=0, err=0, and m_addr/m_wdata=0.
REQ-022 SHALL abandon any access in progress on reset (including mid-RMW): no rsp_valid is produced and m_req falls in the cycle after reset is sampled; the memory SHALL tolerate the abandoned access.

Configuration
REQ-023 SHALL support macro MIPS_MEM_BYTE_ENABLE_EN. When defined, it adds output `m_be` (4 bits); sb/sh/sw go directly to WR with m_be = lane mask (sb 0001<<lane, sh 0011 or 1100, sw 1111) and wdata replicated across lanes; sb/sh then respond at T+2.
REQ-024 SHALL, when MIPS_MEM_BYTE_ENABLE_EN is undefined, have no m_be port and perform sb/sh by RMW per REQ-012/REQ-016.

Structure
REQ-025 SHALL place the sel encoding constants, the FSM state type and the lane-mask constants in shared package mips_mem_pkg.
REQ-026 SHALL implement lane select and extension in combinational sub-module mips_load_extend (inputs word, addr[1:0], sel; output 32-bit result).

Verification
REQ-027 SHALL cover lb at addr 0x103 with m_rdata=0x80FF_1234 -> rdata=0xFFFF_FF80; the same access with lbu -> 0x0000_0080.
REQ-028 SHALL cover lh at addr 0x2002 with m_rdata=0x9ABC_0000 -> rdata=0xFFFF_9ABC, with rsp_valid at T+2 under zero-wait memory.
REQ-029 SHALL cover sb at addr 0x41 with wdata=0xAA, old word 0x1122_3344, without the macro -> an RD then a WR with m_wdata=0x1122_AA44 and rsp at T+3; with the macro -> a single WR with m_be=0010.
REQ-030 SHALL cover sw at addr 0x6 -> err=1 at T+1 with m_req never asserted; also mem_read=mem_write=1 -> err=1.
REQ-031 SHALL cover a load whose m_ack is delayed 3 cycles -> m_addr stable throughout and rsp at T+5; reset asserted in a WR wait cycle -> no rsp_valid, m_req=0 next cycle, req_ready=1.
